// File: rtl/pulse_rate_meter_pkg.sv
// Shared constants and types for the pulse rate meter and its sibling LED tick counter.
// Both blocks derive their default gate from the same half-second helper.
package pulse_rate_meter_pkg;

    localparam int unsigned DefaultClkFreq  = 25_000_000;
    localparam int unsigned DefaultCntWidth = 8;

    typedef enum logic {
        StIdle    = 1'b0,
        StMeasure = 1'b1
    } state_e;

    function automatic int unsigned half_second_gate(input int unsigned clk_freq);
        return clk_freq / 2;
    endfunction

    localparam int unsigned DefaultGateCycles = half_second_gate(DefaultClkFreq);

endpackage

// File: rtl/pulse_rate_meter_if.sv
// Measurement-side signal bundle: enable and raw input in, result and monitor strobes out.
interface pulse_rate_meter_if
    import pulse_rate_meter_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = DefaultCntWidth
) ();

    logic                 en;
    logic                 sig_in;
    logic [CNT_WIDTH-1:0] count_out;
    logic                 count_valid;
    logic                 overflow;
    logic                 edge_pulse;

    modport master (
        output en,
        output sig_in,
        input  count_out,
        input  count_valid,
        input  overflow,
        input  edge_pulse
    );

    modport slave (
        input  en,
        input  sig_in,
        output count_out,
        output count_valid,
        output overflow,
        output edge_pulse
    );

endinterface

// File: rtl/pulse_rate_meter_sync_edge_detect.sv
// Two-flop synchronizer plus history flop; emits the synchronized level and a rising-edge pulse.
// All flops reset high so a level held through reset never looks like an edge.
module sync_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic level_o,
    output logic rise_o
);

    logic sync1_d, sync1_q;
    logic sync2_d, sync2_q;
    logic hist_d, hist_q;

    always_comb begin
        sync1_d = sig_i;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
        end
    end

    assign level_o = sync2_q;
    assign rise_o  = sync2_q & ~hist_q;

endmodule

// File: rtl/pulse_rate_meter.sv
// Counts synchronized rising edges of sig_in over back-to-back gate windows and publishes
// one saturating count per window, with an overflow flag when edges were lost to saturation.
module pulse_rate_meter
    import pulse_rate_meter_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = DefaultClkFreq,
    parameter int unsigned GATE_CYCLES = half_second_gate(CLK_FREQ),
    parameter int unsigned CNT_WIDTH   = DefaultCntWidth
) (
    input logic               clk,
    input logic               rst_n,
    pulse_rate_meter_if.slave bus
);

    localparam int unsigned GateWidth = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GateWidth-1:0] GateLast = GateWidth'(GATE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CntMax   = '1;

    if (GATE_CYCLES < 2) begin : g_gate_check
        $error("GATE_CYCLES must be at least 2");
    end

    logic sig_level;
    logic edge_pulse;
    logic unused_sig_level;

    sync_edge_detect u_sync_edge_detect (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .sig_i   (bus.sig_in),
        .level_o (sig_level),
        .rise_o  (edge_pulse)
    );

    assign unused_sig_level = sig_level;

    state_e               state_d, state_q;
    logic [GateWidth-1:0] gate_d, gate_q;
    logic [CNT_WIDTH-1:0] edge_cnt_d, edge_cnt_q;
    logic                 ovf_int_d, ovf_int_q;
    logic [CNT_WIDTH-1:0] count_out_d, count_out_q;
    logic                 overflow_d, overflow_q;
    logic                 count_valid_d, count_valid_q;

    logic                 edge_sat;
    logic [CNT_WIDTH-1:0] edge_next;
    logic                 ovf_next;

    // Edge count and overflow bit as they stand once this cycle's pulse is folded in; the
    // terminal cycle publishes these so an edge landing on the last gate cycle still counts.
    always_comb begin
        edge_sat  = (edge_cnt_q == CntMax);
        edge_next = edge_cnt_q;
        if (edge_pulse && !edge_sat) begin
            edge_next = edge_cnt_q + CNT_WIDTH'(1);
        end
        ovf_next = ovf_int_q | (edge_pulse & edge_sat);
    end

    always_comb begin
        state_d       = state_q;
        gate_d        = gate_q;
        edge_cnt_d    = edge_cnt_q;
        ovf_int_d     = ovf_int_q;
        count_out_d   = count_out_q;
        overflow_d    = overflow_q;
        count_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                gate_d     = '0;
                edge_cnt_d = '0;
                ovf_int_d  = 1'b0;
                if (bus.en) begin
                    state_d = StMeasure;
                end
            end

            StMeasure: begin
                if (gate_q == GateLast) begin
                    // Result is published even if en drops on this very cycle.
                    count_out_d   = edge_next;
                    overflow_d    = ovf_next;
                    count_valid_d = 1'b1;
                    gate_d        = '0;
                    edge_cnt_d    = '0;
                    ovf_int_d     = 1'b0;
                    if (!bus.en) begin
                        state_d = StIdle;
                    end
                end else if (!bus.en) begin
                    state_d    = StIdle;
                    gate_d     = '0;
                    edge_cnt_d = '0;
                    ovf_int_d  = 1'b0;
                end else begin
                    gate_d     = gate_q + GateWidth'(1);
                    edge_cnt_d = edge_next;
                    ovf_int_d  = ovf_next;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            gate_q        <= '0;
            edge_cnt_q    <= '0;
            ovf_int_q     <= 1'b0;
            count_out_q   <= '0;
            overflow_q    <= 1'b0;
            count_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            gate_q        <= gate_d;
            edge_cnt_q    <= edge_cnt_d;
            ovf_int_q     <= ovf_int_d;
            count_out_q   <= count_out_d;
            overflow_q    <= overflow_d;
            count_valid_q <= count_valid_d;
        end
    end

    assign bus.count_out   = count_out_q;
    assign bus.count_valid = count_valid_q;
    assign bus.overflow    = overflow_q;
    assign bus.edge_pulse  = edge_pulse;

endmodule

// File: tb/tb_pulse_rate_meter.sv
// Drives two meter instances (short gate / wide count, long gate / narrow count) with the same
// stimulus and compares every cycle against a window-level reference model.
module tb_pulse_rate_meter;

    localparam int unsigned GateA  = 10;
    localparam int unsigned WidthA = 8;
    localparam int unsigned GateB  = 40;
    localparam int unsigned WidthB = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic sig   = 1'b1;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    int unsigned cyc     = 0;
    int unsigned sig_left = 2;
    int unsigned en_left  = 0;

    // Reference model state, one slot per instance. Edges are counted unbounded and only
    // clamped when a window closes.
    bit          m_meas  [2];
    int unsigned m_pos   [2];
    int unsigned m_edges [2];
    int unsigned m_cnt   [2];
    bit          m_ovf   [2];
    bit          m_valid [2];
    bit          m_pulse [2];
    bit          m_s_new [2];
    bit          m_s_mid [2];
    bit          m_s_old [2];

    pulse_rate_meter_if #(.CNT_WIDTH(WidthA)) bus_a ();
    pulse_rate_meter_if #(.CNT_WIDTH(WidthB)) bus_b ();

    assign bus_a.en     = en;
    assign bus_a.sig_in = sig;
    assign bus_b.en     = en;
    assign bus_b.sig_in = sig;

    pulse_rate_meter #(
        .CLK_FREQ    (20),
        .GATE_CYCLES (GateA),
        .CNT_WIDTH   (WidthA)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    pulse_rate_meter #(
        .CLK_FREQ    (80),
        .GATE_CYCLES (GateB),
        .CNT_WIDTH   (WidthB)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step(input int i);
        int unsigned gate;
        int unsigned cap;
        bit          prev_pulse;
        gate = (i == 0) ? GateA : GateB;
        cap  = (i == 0) ? ((1 << WidthA) - 1) : ((1 << WidthB) - 1);
        if (!rst_n) begin
            m_meas[i]  = 1'b0;
            m_pos[i]   = 0;
            m_edges[i] = 0;
            m_cnt[i]   = 0;
            m_ovf[i]   = 1'b0;
            m_valid[i] = 1'b0;
            m_pulse[i] = 1'b0;
            m_s_new[i] = 1'b1;
            m_s_mid[i] = 1'b1;
            m_s_old[i] = 1'b1;
        end else begin
            prev_pulse = m_pulse[i];
            m_valid[i] = 1'b0;
            if (m_meas[i]) begin
                m_edges[i] += {31'b0, prev_pulse};
                if (m_pos[i] == gate - 1) begin
                    m_cnt[i]   = (m_edges[i] > cap) ? cap : m_edges[i];
                    m_ovf[i]   = (m_edges[i] > cap);
                    m_valid[i] = 1'b1;
                    m_edges[i] = 0;
                    m_pos[i]   = 0;
                    m_meas[i]  = en;
                end else if (!en) begin
                    m_meas[i]  = 1'b0;
                    m_edges[i] = 0;
                    m_pos[i]   = 0;
                end else begin
                    m_pos[i]++;
                end
            end else if (en) begin
                m_meas[i]  = 1'b1;
                m_pos[i]   = 0;
                m_edges[i] = 0;
            end
            // Last three samples of sig_in; a pulse appears two samples after a 0->1 step.
            m_s_old[i] = m_s_mid[i];
            m_s_mid[i] = m_s_new[i];
            m_s_new[i] = sig;
            m_pulse[i] = m_s_mid[i] & ~m_s_old[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        cyc++;
        #1;
        check_eq("a_count_out",   {24'b0, bus_a.count_out},  m_cnt[0]);
        check_eq("a_count_valid", {31'b0, bus_a.count_valid}, 32'(m_valid[0]));
        check_eq("a_overflow",    {31'b0, bus_a.overflow},    32'(m_ovf[0]));
        check_eq("a_edge_pulse",  {31'b0, bus_a.edge_pulse},  32'(m_pulse[0]));
        check_eq("b_count_out",   {29'b0, bus_b.count_out},   m_cnt[1]);
        check_eq("b_count_valid", {31'b0, bus_b.count_valid}, 32'(m_valid[1]));
        check_eq("b_overflow",    {31'b0, bus_b.overflow},    32'(m_ovf[1]));
        check_eq("b_edge_pulse",  {31'b0, bus_b.edge_pulse},  32'(m_pulse[1]));
    endtask

    task automatic step_sig_random();
        if (sig_left == 0) begin
            sig      = ~sig;
            sig_left = ($urandom_range(3, 0) == 0) ? 2 : $urandom_range(7, 2);
        end
        sig_left--;
    endtask

    initial begin
        // Reset with the input held high, then idle.
        rst_n = 1'b0;
        en    = 1'b0;
        sig   = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (50) tick();

        // Slow square wave, 4 high / 4 low, then quiet windows.
        sig = 1'b0;
        en  = 1'b1;
        for (int k = 0; k < 48; k++) begin
            sig = ((k / 4) % 2) == 1;
            tick();
        end
        sig = 1'b0;
        repeat (45) tick();

        // Toggle every 2 cycles to saturate the narrow counter, then a light window.
        for (int k = 0; k < 130; k++) begin
            sig = ((k / 2) % 2) == 1;
            tick();
        end
        for (int k = 0; k < 80; k++) begin
            sig = (k >= 5 && k < 9) || (k >= 15 && k < 19);
            tick();
        end

        // Edge whose pulse lands on the terminal cycle of the short window.
        rst_n = 1'b0;
        en    = 1'b0;
        sig   = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        en = 1'b1;
        tick();
        repeat (7) tick();
        sig = 1'b1;
        tick();
        tick();
        tick();
        check_eq("boundary_valid", {31'b0, bus_a.count_valid}, 32'd1);
        check_eq("boundary_count", {24'b0, bus_a.count_out}, 32'd1);
        sig = 1'b0;
        repeat (10) tick();
        check_eq("boundary_next_valid", {31'b0, bus_a.count_valid}, 32'd1);
        check_eq("boundary_next_count", {24'b0, bus_a.count_out}, 32'd0);

        // Two edges, then drop en at gate count 5, then re-arm.
        for (int k = 0; k < 5; k++) begin
            sig = (k < 2) || (k == 4);
            tick();
        end
        en = 1'b0;
        repeat (15) tick();
        sig = 1'b0;
        en  = 1'b1;
        repeat (25) tick();

        // Reset pulse mid-window, then a clean restart.
        repeat (8) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 60; k++) begin
            step_sig_random();
            tick();
        end

        // Random enable runs, random pulse widths, rare resets.
        for (int k = 0; k < 4000; k++) begin
            if (en_left == 0) begin
                en      = ~en;
                en_left = en ? $urandom_range(150, 5) : $urandom_range(20, 1);
            end
            en_left--;
            step_sig_random();
            rst_n = ($urandom_range(399, 0) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
